// File: rtl/bb_bcd_counter_if.sv
// Bundle of the bb_bcd_counter control inputs and count/display outputs.
// The controller side (master) drives enable, direction, clear, load and hold;
// the counter side (slave) returns the live count, the display copy and the
// one-cycle event strobes.
interface bb_bcd_counter_if #(
  parameter int W = 16
) ();
  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         hold;
  logic [W-1:0] count;
  logic [W-1:0] disp;
  logic         tick;
  logic         tc;
  logic         load_err;

  modport master (
    output en, up, clr, load, load_val, hold,
    input  count, disp, tick, tc, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val, hold,
    output count, disp, tick, tc, load_err
  );
endinterface

// File: rtl/bb_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaler, clear/load, wrap or
// saturate at the ends, terminal-count pulse and a display hold latch.
//
// Handshake: tick is a valid strobe with no ready. It is high for exactly one
// cycle after every accepted count step and count already holds the stepped
// value while tick is high; tc and load_err are likewise one-cycle strobes
// qualified by nothing else. The consumer cannot stall the counter.
module bb_bcd_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 2048,
  parameter int WRAP     = 1
) (
  input  logic             osc_sclk,
  input  logic             rst,
  bb_bcd_counter_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [W-1:0]  count_q;
  logic [W-1:0]  disp_q;
  logic          tick_q;
  logic          tc_q;
  logic          load_err_q;

  logic          step_now;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  load_clean;
  logic          load_bad;
  logic          all_nine;
  logic          all_zero;
  logic          boundary;
  logic [W-1:0]  step_val;

  // A step is due on the edge where the prescaler sits on its last value.
  assign step_now = bus.en && (pre_q == PRE_LAST);

  // Ripple-style BCD increment/decrement and load_val sanitising, digit by digit.
  always_comb begin
    logic [3:0] digit;
    logic [3:0] nib;
    inc_val    = '0;
    dec_val    = '0;
    load_clean = '0;
    load_bad   = 1'b0;
    all_nine   = 1'b1;
    all_zero   = 1'b1;
    digit      = 4'd0;
    nib        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      // A digit moves only when every lower digit is at its rollover value.
      inc_val[4*i +: 4] = all_nine ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
      dec_val[4*i +: 4] = all_zero ? ((digit == 4'd0) ? 4'd9 : digit - 4'd1) : digit;
      all_nine = all_nine & (digit == 4'd9);
      all_zero = all_zero & (digit == 4'd0);
      nib = bus.load_val[4*i +: 4];
      if (nib > 4'd9) begin
        load_bad = 1'b1;
        load_clean[4*i +: 4] = 4'd0;
      end else begin
        load_clean[4*i +: 4] = nib;
      end
    end
  end

  // Value after a step: the natural BCD roll gives the wrap target, so only
  // saturate mode needs to override it at the boundary.
  always_comb begin
    boundary = bus.up ? all_nine : all_zero;
    step_val = bus.up ? inc_val : dec_val;
    if (boundary && (WRAP == 0)) begin
      step_val = count_q;
    end
  end

  // Prescaler: cleared by clr, frozen by en=0, unaffected by load.
  always_ff @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (bus.clr) begin
      pre_q <= '0;
    end else if (bus.en) begin
      pre_q <= step_now ? '0 : pre_q + PW'(1);
    end
  end

  // Counter register with clr > load > step priority.
  always_ff @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.clr) begin
      count_q <= '0;
    end else if (bus.load) begin
      count_q <= load_clean;
    end else if (step_now) begin
      count_q <= step_val;
    end
  end

  // Event strobes; a step swallowed by clr or load produces no tick or tc.
  always_ff @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      tick_q     <= 1'b0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tick_q     <= step_now && !bus.clr && !bus.load;
      tc_q       <= step_now && !bus.clr && !bus.load && boundary;
      load_err_q <= bus.load && !bus.clr && load_bad;
    end
  end

  // Display copy trails count by one register and freezes while hold is high.
  always_ff @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
    end else if (!bus.hold) begin
      disp_q <= count_q;
    end
  end

  assign bus.count    = count_q;
  assign bus.disp     = disp_q;
  assign bus.tick     = tick_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bb_bcd_counter.sv
// Bench for bb_bcd_counter: a wrapping and a saturating instance share the
// same stimulus and are checked against a decimal-arithmetic reference model.
module tb_bb_bcd_counter;

  localparam int D    = 2;
  localparam int P    = 4;
  localparam int W    = 4 * D;
  localparam int MAXV = 99;

  // ---------------- clock / reset ----------------
  logic osc_sclk = 1'b0;
  logic rst;
  always #5 osc_sclk = ~osc_sclk;

  logic         en, up, clr, load, hold;
  logic [W-1:0] load_val;

  bb_bcd_counter_if #(.W(W)) if_w ();
  bb_bcd_counter_if #(.W(W)) if_s ();

  assign if_w.en = en;   assign if_s.en = en;
  assign if_w.up = up;   assign if_s.up = up;
  assign if_w.clr = clr; assign if_s.clr = clr;
  assign if_w.load = load; assign if_s.load = load;
  assign if_w.load_val = load_val; assign if_s.load_val = load_val;
  assign if_w.hold = hold; assign if_s.hold = hold;

  bb_bcd_counter #(.DIGITS(D), .PRESCALE(P), .WRAP(1)) u_wrap (
    .osc_sclk(osc_sclk), .rst(rst), .bus(if_w)
  );
  bb_bcd_counter #(.DIGITS(D), .PRESCALE(P), .WRAP(0)) u_sat (
    .osc_sclk(osc_sclk), .rst(rst), .bus(if_s)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [W:0] exp_q_w[$];
  logic [W:0] exp_q_s[$];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(logic [W-1:0] x);
    int v, m;
    v = 0;
    m = 1;
    for (int i = 0; i < D; i++) begin
      if (x[4*i +: 4] <= 4'd9) v += int'(x[4*i +: 4]) * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(logic [W-1:0] x);
    bit b;
    b = 1'b0;
    for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // ---------------- reference model (decimal values) ----------------
  int m_val[2];
  int m_disp[2];
  bit m_tc[2];
  int m_pre;
  bit m_tick;
  bit m_err;
  bit m_step;

  always @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      m_val = '{0, 0}; m_disp = '{0, 0}; m_tc = '{0, 0};
      m_pre = 0; m_tick = 0; m_err = 0;
    end else begin
      m_step = en && (m_pre == P - 1);
      for (int k = 0; k < 2; k++) if (!hold) m_disp[k] = m_val[k];
      if (clr) m_pre = 0;
      else if (en) m_pre = m_step ? 0 : m_pre + 1;
      m_tick = 0; m_err = 0; m_tc = '{0, 0};
      if (clr) begin
        m_val = '{0, 0};
      end else if (load) begin
        m_val[0] = from_load(load_val);
        m_val[1] = m_val[0];
        m_err = has_bad(load_val);
      end else if (m_step) begin
        m_tick = 1;
        for (int k = 0; k < 2; k++) begin
          if (up) begin
            if (m_val[k] == MAXV) begin m_tc[k] = 1; m_val[k] = (k == 0) ? 0 : MAXV; end
            else m_val[k] = m_val[k] + 1;
          end else begin
            if (m_val[k] == 0) begin m_tc[k] = 1; m_val[k] = (k == 0) ? MAXV : 0; end
            else m_val[k] = m_val[k] - 1;
          end
        end
        exp_q_w.push_back({m_tc[0], to_bcd(m_val[0])});
        exp_q_s.push_back({m_tc[1], to_bcd(m_val[1])});
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic mon(int k, logic [W-1:0] cnt, logic [W-1:0] dsp,
                     logic tk, logic tcv, logic er);
    logic [W:0] e;
    string s;
    s = (k == 0) ? "wrap" : "sat";
    chk({s, "_count"}, int'(cnt), int'(to_bcd(m_val[k])));
    chk({s, "_disp"}, int'(dsp), int'(to_bcd(m_disp[k])));
    chk({s, "_tick"}, int'(tk), int'(m_tick));
    chk({s, "_tc"}, int'(tcv), int'(m_tc[k]));
    chk({s, "_load_err"}, int'(er), int'(m_err));
    if (tk) begin
      if ((k == 0 ? exp_q_w.size() : exp_q_s.size()) == 0) begin
        chk({s, "_unexpected_tick"}, 1, 0);
      end else begin
        e = (k == 0) ? exp_q_w.pop_front() : exp_q_s.pop_front();
        chk({s, "_step_result"}, int'({tcv, cnt}), int'(e));
      end
    end
  endtask

  always @(negedge osc_sclk) begin
    if (!rst) begin
      mon(0, if_w.count, if_w.disp, if_w.tick, if_w.tc, if_w.load_err);
      mon(1, if_s.count, if_s.disp, if_s.tick, if_s.tc, if_s.load_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(int n);
    repeat (n) @(negedge osc_sclk);
  endtask

  task automatic steps(int n);
    cycles(n * P);
  endtask

  task automatic load_pulse(logic [W-1:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge osc_sclk);
    load = 1'b0;
  endtask

  task automatic wait_pre(int target);
    for (int i = 0; i < 2 * P + 8 && m_pre != target; i++) @(negedge osc_sclk);
    chk("wait_pre_reached", m_pre, target);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_count_w"}, int'(if_w.count), 0);
    chk({tag, "_count_s"}, int'(if_s.count), 0);
    chk({tag, "_disp_w"}, int'(if_w.disp), 0);
    chk({tag, "_strobes_w"}, int'({if_w.tick, if_w.tc, if_w.load_err}), 0);
    chk({tag, "_strobes_s"}, int'({if_s.tick, if_s.tc, if_s.load_err}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; hold = 1'b0;
    cycles(2);
    chk_zero("reset");
    rst = 1'b0;

    // Full up sweep: wrap instance rolls 99->00, saturating one sticks at 99.
    en = 1'b1;
    steps(101);

    // Clear, then count down through the borrows.
    clr = 1'b1; @(negedge osc_sclk); clr = 1'b0;
    up = 1'b0;
    steps(62);

    // Boundary loads near each end.
    load_pulse(8'h98); up = 1'b1; steps(4);
    load_pulse(8'h01); up = 1'b0; steps(3);

    // Invalid nibble, load with clr, load on a step edge.
    load_pulse(8'hA7); cycles(2);
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    @(negedge osc_sclk);
    clr = 1'b0; load = 1'b0;
    cycles(2);
    wait_pre(P - 1);
    load_pulse(8'h42);
    steps(2);

    // Display hold across ten steps, then release.
    load_pulse(8'h25); up = 1'b1;
    cycles(1);
    hold = 1'b1;
    steps(10);
    hold = 1'b0;
    cycles(3);

    // Enable dropped mid-prescale.
    wait_pre(2);
    en = 1'b0; cycles(7); en = 1'b1;
    steps(2);

    // Asynchronous reset between edges.
    @(posedge osc_sclk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    #1 rst = 1'b0;
    steps(3);

    // Randomised mix.
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      clr      = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 24) == 0) hold = ~hold;
      @(negedge osc_sclk);
    end
    en = 1'b1; clr = 1'b0; load = 1'b0; hold = 1'b0;
    cycles(3);

    chk("queue_empty_w", exp_q_w.size(), 0);
    chk("queue_empty_s", exp_q_s.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
